serial_adder_feeder: RTL and testbench

Parallel-to-serial front end for the bit-serial adder. Accepts a pair of WIDTH-bit operands through a valid/ready handshake, then streams them LSB-first as `vld`/`a`/`b`/`last`. It captures the returned `sum` bit on every valid cycle and presents the assembled WIDTH-bit result as a one-cycle pulse. The block sits between a parallel producer and the serial adder, and drives the serial side of the adder's protocol.

---
 rtl/serial_pkg.sv | 13 +
 rtl/serial_adder_feeder.sv | 80 ++++++++
 tb/tb_serial_adder_feeder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial adder front end.
package serial_pkg;

  typedef enum logic {IDLE, SHIFT} feeder_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-counter width: enough to index bits 0..w-1, never narrower than 1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_feeder.sv
// Parallel-to-serial feeder for the bit-serial adder: streams operands LSB-first
// and reassembles the returned sum bits into a parallel result strobe.
module serial_adder_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             pause,
  output logic             vld,
  output logic             a,
  output logic             b,
  output logic             last,
  input  logic             sum,
  output logic             res_vld,
  output logic [WIDTH-1:0] res
);

  localparam int CW = cnt_width(WIDTH);

  feeder_state_t    state;
  logic [WIDTH-1:0] sh_a, sh_b, acc;
  logic [CW-1:0]    cnt;
  logic             emit, is_last;

  // Serial side is combinational so a pause suppresses the bit in the same cycle.
  assign emit     = (state == SHIFT) && !pause && !rst;
  assign is_last  = (cnt == CW'(WIDTH-1));
  assign vld      = emit;
  assign a        = emit & sh_a[0];
  assign b        = emit & sh_b[0];
  assign last     = emit & is_last;
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      acc     <= '0;
      cnt     <= '0;
      res     <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a  <= in_a;
            sh_b  <= in_b;
            acc   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!pause) begin
            acc[cnt] <= sum;
            sh_a     <= sh_a >> 1;
            sh_b     <= sh_b >> 1;
            cnt      <= cnt + 1'b1;
            if (is_last) begin
              // Top bit arrives this cycle, so merge it straight into the result.
              res     <= {sum, acc[WIDTH-2:0]};
              res_vld <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_feeder.sv
// Directed bench for serial_adder_feeder with a behavioural bit-serial adder partner.
module tb_serial_adder_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0, in_b = '0;
  logic       pause = 1'b0;
  logic       vld, a, b, last, sum, res_vld;
  logic [7:0] res;
  logic       carry;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  serial_adder_feeder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .pause(pause), .vld(vld), .a(a), .b(b),
    .last(last), .sum(sum), .res_vld(res_vld), .res(res)
  );

  // Downstream adder: holds carry when idle, clears it on last and on reset.
  assign sum = a ^ b ^ carry;
  always @(posedge clk) begin
    if (rst)      carry <= 1'b0;
    else if (vld) carry <= last ? 1'b0 : ((a & b) | (carry & (a ^ b)));
  end

  // Stimulus helper: one handshake, then wait (bounded) for the result strobe.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                        output int lat, output logic [7:0] r);
    @(posedge clk); #1 in_valid = 1'b1; in_a = x; in_b = y;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = -1;
    r   = 'x;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (res_vld) begin lat = t; r = res; break; end
    end
  endtask

  task automatic test_reset;
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if ({vld, a, b, last, res_vld} !== 5'b0) begin failures++; $display("FAIL reset_outs got=%b exp=00000", {vld, a, b, last, res_vld}); end
    checks++; if (res !== 8'h00) begin failures++; $display("FAIL reset_res got=%h exp=00", res); end
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (vld !== 1'b0) begin failures++; $display("FAIL reset_no_accept vld=%b exp=0", vld); end
  endtask

  task automatic test_basic;
    logic [7:0] xa;
    logic [7:0] xb;
    xa = 8'h5A; xb = 8'h3C;
    @(posedge clk); #1 in_valid = 1'b1; in_a = xa; in_b = xb;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
      @(negedge clk);
      checks++;
      if ({vld, a, b, last, in_ready} !== {1'b1, xa[i], xb[i], (i == 7), 1'b0}) begin
        failures++;
        $display("FAIL basic_bit%0d got vld/a/b/last/rdy=%b exp=%b", i,
                 {vld, a, b, last, in_ready}, {1'b1, xa[i], xb[i], (i == 7), 1'b0});
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (res_vld !== 1'b1 || res !== 8'h96) begin failures++; $display("FAIL basic_result res_vld=%b res=%h exp 1/96", res_vld, res); end
    checks++; if (in_ready !== 1'b1 || vld !== 1'b0) begin failures++; $display("FAIL basic_idle rdy=%b vld=%b exp 1/0", in_ready, vld); end
    @(negedge clk);
    checks++; if (res_vld !== 1'b0 || res !== 8'h96) begin failures++; $display("FAIL basic_hold res_vld=%b res=%h exp 0/96", res_vld, res); end
  endtask

  task automatic test_overflow;
    int lat;
    logic [7:0] r;
    run_op(8'hFF, 8'h01, lat, r);
    checks++; if (lat !== 9 || r !== 8'h00) begin failures++; $display("FAIL overflow lat=%0d res=%h exp 9/00", lat, r); end
    run_op(8'h00, 8'h00, lat, r);
    checks++; if (lat !== 9 || r !== 8'h00) begin failures++; $display("FAIL carry_cleared lat=%0d res=%h exp 9/00", lat, r); end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1 in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      if (c == 1)  begin in_a = 8'h80; in_b = 8'h80; end
      if (c == 10) begin in_valid = 1'b0; in_a = 8'hFF; in_b = 8'hFF; end
      @(negedge clk);
      if (c == 9) begin
        checks++; if (res_vld !== 1'b1 || res !== 8'h46 || in_ready !== 1'b1) begin failures++; $display("FAIL b2b_first res_vld=%b res=%h rdy=%b exp 1/46/1", res_vld, res, in_ready); end
      end else if (c == 18) begin
        checks++; if (res_vld !== 1'b1 || res !== 8'h00) begin failures++; $display("FAIL b2b_second res_vld=%b res=%h exp 1/00", res_vld, res); end
      end else begin
        checks++; if (res_vld !== 1'b0 || vld !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL b2b_cycle%0d res_vld=%b vld=%b rdy=%b exp 0/1/0", c, res_vld, vld, in_ready); end
      end
      if (c == 10 || c == 17) begin
        checks++; if (a !== (c == 17) || last !== (c == 17)) begin failures++; $display("FAIL b2b_bits_c%0d a=%b last=%b", c, a, last); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_pause;
    logic [7:0] xa;
    int k;
    xa = 8'h0F;
    k  = 0;
    @(posedge clk); #1 in_valid = 1'b1; in_a = xa; in_b = 8'h01;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1 in_valid = 1'b0;
      pause = (c >= 5 && c <= 7) || (c == 11);
      @(negedge clk);
      if (pause) begin
        checks++; if ({vld, a, b, last} !== 4'b0) begin failures++; $display("FAIL pause_quiet_c%0d got=%b exp=0000", c, {vld, a, b, last}); end
      end else begin
        checks++; if (vld !== 1'b1 || a !== xa[k] || last !== (k == 7)) begin failures++; $display("FAIL pause_bit%0d_c%0d vld=%b a=%b last=%b", k, c, vld, a, last); end
        k++;
      end
      checks++; if (res_vld !== 1'b0) begin failures++; $display("FAIL pause_early_strobe c%0d res_vld=%b exp=0", c, res_vld); end
    end
    @(posedge clk); #1 pause = 1'b0;
    @(negedge clk);
    checks++; if (res_vld !== 1'b1 || res !== 8'h10) begin failures++; $display("FAIL pause_result res_vld=%b res=%h exp 1/10", res_vld, res); end
  endtask

  task automatic test_reset_mid_op;
    int seen;
    int lat;
    logic [7:0] r;
    seen = 0;
    @(posedge clk); #1 in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1 in_valid = 1'b0;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checks++; if ({vld, a, b, last, in_ready} !== 5'b0) begin failures++; $display("FAIL midreset_during got=%b exp=00000", {vld, a, b, last, in_ready}); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (res !== 8'h00 || vld !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL midreset_after res=%h vld=%b rdy=%b exp 00/0/1", res, vld, in_ready); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (res_vld || vld) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midreset_no_strobe activity=%0d exp=0", seen); end
    run_op(8'h01, 8'h02, lat, r);
    checks++; if (lat !== 9 || r !== 8'h03) begin failures++; $display("FAIL midreset_next lat=%0d res=%h exp 9/03", lat, r); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_back_to_back;
    test_pause;
    test_reset_mid_op;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
